// File: rtl/m68k_bus_responder.sv
// 68000 asynchronous-bus slave with an internal 16-bit RAM, programmable wait states and byte strobes.
// Optional macro M68K_RESPONDER_BERR_EN answers out-of-depth in-window offsets with BERR instead of aliasing.
module m68k_bus_responder #(
  parameter logic [7:0] BASE        = 8'h00,
  parameter int         ADDR_BITS   = 8,
  parameter int         WAIT_STATES = 2
) (
  input  logic        M68K_CLK,
  input  logic        RESET,
  input  logic [22:0] M68K_A,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic        BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [1:0]             as_sync, uds_sync, lds_sync, rw_sync;
  logic                   as, uds, lds, rw;
  logic                   start;
  logic                   we;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [15:0]            data_q;
  logic                   rw_q, uds_q, lds_q;
  logic                   dtack_q, d_oe_q;
  logic [15:0]            d_out_q;
  logic [15:0]            mem [0:(1<<ADDR_BITS)-1];
  logic                   unused_a;

  // Strobes are asynchronous to M68K_CLK; address and data are assumed stable once AS is seen.
  always_ff @(posedge M68K_CLK) begin
    if (RESET) begin
      as_sync  <= 2'b11;
      uds_sync <= 2'b11;
      lds_sync <= 2'b11;
      rw_sync  <= 2'b11;
    end else begin
      as_sync  <= {as_sync[0],  M68K_AS_n};
      uds_sync <= {uds_sync[0], M68K_UDS_n};
      lds_sync <= {lds_sync[0], M68K_LDS_n};
      rw_sync  <= {rw_sync[0],  M68K_RW};
    end
  end

  assign as  = ~as_sync[1];
  assign uds = ~uds_sync[1];
  assign lds = ~lds_sync[1];
  assign rw  = rw_sync[1];

  assign start    = as && (uds || lds) && (M68K_A[22:15] == BASE);
  assign unused_a = ^M68K_A[14:ADDR_BITS];

`ifdef M68K_RESPONDER_BERR_EN
  logic start_err, err_q, berr_q;
  assign start_err   = |M68K_A[14:ADDR_BITS];
  assign M68K_BERR_n = berr_q;
`else
  assign M68K_BERR_n = 1'b1;
`endif

  always_ff @(posedge M68K_CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      dtack_q <= 1'b1;
      d_oe_q  <= 1'b0;
      d_out_q <= 16'h0000;
`ifdef M68K_RESPONDER_BERR_EN
      err_q   <= 1'b0;
      berr_q  <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= M68K_A[ADDR_BITS-1:0];
            data_q <= M68K_D_IN;
            rw_q   <= rw;
            uds_q  <= uds;
            lds_q  <= lds;
            cnt    <= 4'(WAIT_STATES);
`ifdef M68K_RESPONDER_BERR_EN
            err_q  <= start_err;
            state  <= start_err ? S_ACK : S_WAIT;
`else
            state  <= S_WAIT;
`endif
          end
        end
        // WAIT always lasts WAIT_STATES+1 cycles, so WAIT_STATES==0 reaches ACK at C0+1.
        S_WAIT: begin
          d_out_q <= mem[addr_q];
          d_oe_q  <= rw_q;
          if (cnt == 4'd0) begin
            state   <= S_ACK;
            dtack_q <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          if (!as) begin
            state   <= S_RELEASE;
            dtack_q <= 1'b1;
            d_oe_q  <= 1'b0;
`ifdef M68K_RESPONDER_BERR_EN
            berr_q  <= 1'b1;
          end else if (err_q) begin
            berr_q  <= 1'b0;
`endif
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
`ifdef M68K_RESPONDER_BERR_EN
          err_q <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The write lands on the edge that enters ACK; a reset on that edge suppresses it.
  assign we = (state == S_WAIT) && (cnt == 4'd0) && !rw_q && !RESET;

  always_ff @(posedge M68K_CLK) begin
    if (we) begin
      if (uds_q) mem[addr_q][15:8] <= data_q[15:8];
      if (lds_q) mem[addr_q][7:0]  <= data_q[7:0];
    end
  end

  assign M68K_D_OUT   = d_out_q;
  assign M68K_D_OE    = d_oe_q;
  assign M68K_DTACK_n = dtack_q;
  assign BUSY         = (state != S_IDLE);

endmodule
